// File: rtl/haze_pkg.sv
// Shared types and constants for the dehaze frame controller.
package haze_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] OMEGA_DEF_Q08 = 8'd243;
    localparam logic [7:0] T0_DEF_Q08    = 8'd26;
    localparam logic [7:0] A_DEF_VAL     = 8'd255;

    // One spare bit above the exact frame size so a saturated count can never alias a good frame.
    function automatic int pix_cnt_width(input int w, input int h);
        return $clog2(w * h + 1) + 1;
    endfunction

endpackage

// File: rtl/frame_stat_acc.sv
// Per-frame statistics: saturating accepted-pixel counter and running 8-bit maximum.
module frame_stat_acc #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic [7:0]    pix,
    output logic [CW-1:0] count,
    output logic [7:0]    max_val
);

    logic [CW-1:0] count_q, count_d;
    logic [7:0]    max_q, max_d;

    // Clear and accept may coincide: the pixel of the clearing cycle starts the new frame.
    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        if (clear) begin
            count_d = '0;
            max_d   = '0;
        end
        if (accept) begin
            if (count_d != '1) begin
                count_d = count_d + 1'b1;
            end
            if (pix > max_d) begin
                max_d = pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    assign count   = count_q;
    assign max_val = max_q;

endmodule

// File: rtl/haze_frame_ctrl.sv
// Frame-boundary controller: atmospheric light, pixel-count check, shadowed omega/t0.
// Define ATM_LIGHT_IIR_EN to smooth atm_light across frames with a 3/4 IIR.
module haze_frame_ctrl
    import haze_pkg::*;
#(
    parameter int         PIC_WIDTH  = 640,
    parameter int         PIC_HEIGHT = 480,
    parameter logic [7:0] OMEGA_DEF  = OMEGA_DEF_Q08,
    parameter logic [7:0] T0_DEF     = T0_DEF_Q08,
    parameter logic [7:0] A_DEF      = A_DEF_VAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dc_frame_vsync,
    input  logic        dc_frame_href,
    input  logic        dc_frame_clken,
    input  logic [7:0]  dc_img,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_omega,
    input  logic [7:0]  cfg_t0,
    output logic [7:0]  atm_light,
    output logic [7:0]  omega,
    output logic [7:0]  t0,
    output logic        param_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int          CW        = pix_cnt_width(PIC_WIDTH, PIC_HEIGHT);
    localparam logic [CW-1:0] FRAME_PIX = CW'(PIC_WIDTH * PIC_HEIGHT);

    state_e        state_q;
    logic          vsync_q;
    logic [7:0]    atm_light_q, omega_q, t0_q;
    logic          param_valid_q, frame_done_q, frame_err_q;
    logic [15:0]   frame_cnt_q;
    logic          pend_valid_q;
    logic [7:0]    pend_omega_q, pend_t0_q;

    logic          pix_ok, vsync_rise, acc_clear, acc_accept, frame_good;
    logic [CW-1:0] acc_count;
    logic [7:0]    acc_max, new_a;

    assign pix_ok     = dc_frame_vsync & dc_frame_href & dc_frame_clken;
    assign vsync_rise = dc_frame_vsync & ~vsync_q;
    assign acc_clear  = (state_q == IDLE) & vsync_rise;
    assign acc_accept = pix_ok & ((state_q == ACTIVE) | acc_clear);
    assign frame_good = (acc_count == FRAME_PIX);

    frame_stat_acc #(
        .CW(CW)
    ) u_stat (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .accept  (acc_accept),
        .pix     (dc_img),
        .count   (acc_count),
        .max_val (acc_max)
    );

`ifdef ATM_LIGHT_IIR_EN
    logic [9:0] iir_sum;
    assign iir_sum = {2'b00, atm_light_q} * 10'd3 + {2'b00, acc_max} + 10'd2;
    // The first good frame seeds the filter so it does not start from the reset default.
    assign new_a   = param_valid_q ? iir_sum[9:2] : acc_max;
`else
    assign new_a   = acc_max;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b1;
            atm_light_q   <= A_DEF;
            omega_q       <= OMEGA_DEF;
            t0_q          <= T0_DEF;
            param_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= 16'd0;
            pend_valid_q  <= 1'b0;
            pend_omega_q  <= 8'd0;
            pend_t0_q     <= 8'd0;
        end else begin
            vsync_q      <= dc_frame_vsync;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (cfg_valid && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_omega_q <= cfg_omega;
                pend_t0_q    <= cfg_t0;
            end

            case (state_q)
                IDLE: begin
                    if (vsync_rise) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!dc_frame_vsync) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (frame_good) begin
                        atm_light_q   <= new_a;
                        param_valid_q <= 1'b1;
                    end
                    // A write landing this cycle cannot collide: cfg_ready is low while pending.
                    if (pend_valid_q) begin
                        omega_q      <= pend_omega_q;
                        t0_q         <= pend_t0_q;
                        pend_valid_q <= 1'b0;
                    end
                    frame_done_q <= 1'b1;
                    frame_err_q  <= ~frame_good;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready   = ~pend_valid_q;
    assign atm_light   = atm_light_q;
    assign omega       = omega_q;
    assign t0          = t0_q;
    assign param_valid = param_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_haze_frame_ctrl.sv
// Directed and randomized frames against a frame-level reference model of haze_frame_ctrl.
module tb_haze_frame_ctrl;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int CW = $clog2(N + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync, href, clken;
    logic [7:0]  img;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_omega, cfg_t0;
    logic [7:0]  atm_light, omega, t0;
    logic        param_valid, frame_done, frame_err;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_a, m_om, m_t0, m_pv, m_cnt, m_pend, m_pom, m_pt0;
    int cfg_om_val, cfg_t0_val;

    haze_frame_ctrl #(
        .PIC_WIDTH  (W),
        .PIC_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dc_frame_vsync (vsync),
        .dc_frame_href  (href),
        .dc_frame_clken (clken),
        .dc_img         (img),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_omega      (cfg_omega),
        .cfg_t0         (cfg_t0),
        .atm_light      (atm_light),
        .omega          (omega),
        .t0             (t0),
        .param_valid    (param_valid),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 255; m_om = 243; m_t0 = 26; m_pv = 0; m_cnt = 0; m_pend = 0;
        m_pom = 0; m_pt0 = 0;
    endtask

    function automatic int next_a(input int a, input int mx, input int pv);
`ifdef ATM_LIGHT_IIR_EN
        if (pv != 0) return (3 * a + mx + 2) / 4;
`endif
        return mx;
    endfunction

    task automatic chk_outputs(input string tag, input int exp_done, input int exp_err);
        chk({tag, "_done"}, int'(frame_done), exp_done);
        chk({tag, "_err"}, int'(frame_err), exp_err);
        chk({tag, "_atm"}, int'(atm_light), m_a);
        chk({tag, "_omega"}, int'(omega), m_om);
        chk({tag, "_t0"}, int'(t0), m_t0);
        chk({tag, "_pvalid"}, int'(param_valid), m_pv);
        chk({tag, "_fcnt"}, int'(frame_cnt), m_cnt);
        chk({tag, "_ready"}, int'(cfg_ready), (m_pend != 0) ? 0 : 1);
    endtask

    // Sends n accepted pixels in lines of W with random strobe gaps; base<0 means random values.
    task automatic send_frame(input string tag, input int n, input int base, input int peak,
                              input int peak_idx, input int cfg_idx, input int rst_idx,
                              input bit cfg_commit);
        int  acc_n, acc_max, i, col, v, good, wr_ok;
        bit  dead, did_rst, did_cfg;
        acc_n = 0; acc_max = 0; i = 0; col = 0; dead = 0;
        vsync = 1'b1;
        while (i < n) begin
            did_rst = 0; did_cfg = 0;
            href  = 1'b1;
            clken = ($urandom_range(0, 3) != 0);
            if (clken) begin
                v   = (i == peak_idx) ? peak : ((base < 0) ? int'($urandom_range(0, 250)) : base);
                img = 8'(v);
                if (i == cfg_idx) begin
                    cfg_valid = 1'b1; cfg_omega = 8'(cfg_om_val); cfg_t0 = 8'(cfg_t0_val);
                    did_cfg = 1;
                end
                if (i == rst_idx) begin
                    rst = 1'b1;
                    #1;
                    model_reset();
                    chk_outputs({tag, "_inrst"}, 0, 0);
                    dead = 1; did_rst = 1;
                end
                if (!dead) begin
                    acc_n++;
                    if (v > acc_max) acc_max = v;
                end
                i++; col++;
            end else begin
                img = 8'($urandom_range(0, 255));
            end
            step();
            if (did_rst) rst = 1'b0;
            if (did_cfg) begin
                cfg_valid = 1'b0;
                if (m_pend == 0) begin
                    m_pend = 1; m_pom = cfg_om_val; m_pt0 = cfg_t0_val;
                end
                chk({tag, "_ready_after_wr"}, int'(cfg_ready), 0);
            end
            if (col == W) begin
                col = 0; href = 1'b0; clken = 1'b1; img = 8'd255;
                step(); step();
            end
        end
        // cycle k: first cycle with vsync low
        href = 1'b0; clken = 1'b0; vsync = 1'b0;
        step();
        chk({tag, "_k1_done"}, int'(frame_done), 0);
        chk({tag, "_k1_omega"}, int'(omega), m_om);
        if (cfg_commit) begin
            cfg_valid = 1'b1; cfg_omega = 8'(cfg_om_val); cfg_t0 = 8'(cfg_t0_val);
        end
        wr_ok = (cfg_commit && m_pend == 0) ? 1 : 0;
        step();
        cfg_valid = 1'b0;
        good = (acc_n == N) ? 1 : 0;
        if (!dead) begin
            if (good != 0) begin
                m_a  = next_a(m_a, acc_max, m_pv);
                m_pv = 1;
            end
            if (m_pend != 0) begin
                m_om = m_pom; m_t0 = m_pt0; m_pend = 0;
            end
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (wr_ok != 0) begin
            m_pend = 1; m_pom = cfg_om_val; m_pt0 = cfg_t0_val;
        end
        chk_outputs({tag, "_k2"}, dead ? 0 : 1, (!dead && good == 0) ? 1 : 0);
        $display("frame %s: pixels=%0d max=%0d atm=%0d omega=%0d t0=%0d err=%0d cnt=%0d",
                 tag, acc_n, acc_max, atm_light, omega, t0, frame_err, frame_cnt);
        // noisy gap with vsync low: nothing here may be counted
        href = 1'b1; clken = 1'b1; img = 8'd255;
        step();
        chk({tag, "_k3_done"}, int'(frame_done), 0);
        chk({tag, "_k3_err"}, int'(frame_err), 0);
        step(); step();
        href = 1'b0; clken = 1'b0;
        step();
    endtask

    initial begin
        int n, kind, cidx;
        rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; img = 8'd0;
        cfg_valid = 1'b0; cfg_omega = 8'd0; cfg_t0 = 8'd0;
        model_reset();
        step(); step();
        chk_outputs("reset", 0, 0);
        rst = 1'b0;
        step();

        send_frame("good", N, 40, 200, 57, -1, -1, 1'b0);
        cfg_om_val = 200; cfg_t0_val = 30;
        send_frame("cfg_mid", N, 40, 150, 3, 20, -1, 1'b0);
        cfg_om_val = 77; cfg_t0_val = 12;
        send_frame("short", N - W, 30, 90, 5, 10, -1, 1'b0);
        send_frame("rst_mid", N, 40, 220, 2, -1, 4 * W + 3, 1'b0);
        send_frame("after_rst", N, 40, 200, 9, -1, -1, 1'b0);
        cfg_om_val = 10; cfg_t0_val = 5;
        send_frame("cfg_commit", N, 40, 100, 70, -1, -1, 1'b1);
        send_frame("cfg_applied", N, 20, 60, 0, -1, -1, 1'b0);
        send_frame("saturate", (1 << CW) + N, 10, 250, 1, -1, -1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            kind = int'($urandom_range(0, 2));
            n = (kind == 0) ? N : ((kind == 1) ? N - int'($urandom_range(1, 5))
                                               : N + int'($urandom_range(1, 5)));
            cidx = ($urandom_range(0, 1) != 0 && m_pend == 0) ? int'($urandom_range(0, n - 1)) : -1;
            cfg_om_val = int'($urandom_range(0, 255));
            cfg_t0_val = int'($urandom_range(0, 255));
            send_frame($sformatf("rand%0d", f), n, -1, 0, -1, cidx, -1,
                       1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
